// File: rtl/tdm_demux.sv
// Two-channel TDM demultiplexer: collects one A word and one B word, in either
// arrival order, and presents them together as a pair with valid/ready handshakes.
module tdm_demux #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic [7:0]       dup_cnt
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HAVE_A = 2'd1,
        HAVE_B = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t state;
    logic   accept;
    logic   dup_inc;

    // Nothing is taken while a pair is pending or while reset is held.
    assign in_ready  = rst_n & (state != FULL);
    assign out_valid = (state == FULL);
    assign accept    = in_valid & in_ready;

    // A repeated channel tag before the pair completes counts as a duplicate.
    assign dup_inc = accept &
                     (((state == HAVE_A) & ~in_sel) | ((state == HAVE_B) & in_sel));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= EMPTY;
            a_data  <= '0;
            b_data  <= '0;
            dup_cnt <= '0;
        end else begin
            if (accept) begin
                if (in_sel) begin
                    b_data <= in_data;
                end else begin
                    a_data <= in_data;
                end
            end

            if (dup_inc && (dup_cnt != CNT_MAX)) begin
                dup_cnt <= dup_cnt + CNT_W'(1);
            end

            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= in_sel ? HAVE_B : HAVE_A;
                    end
                end
                HAVE_A: begin
                    if (accept && in_sel) begin
                        state <= FULL;
                    end
                end
                HAVE_B: begin
                    if (accept && !in_sel) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed plus randomized bench for tdm_demux against a channel-presence reference model.
module tb_tdm_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_sel;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] a_data;
    logic [1:0] b_data;
    logic [7:0] dup_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: which channels are held, their values, duplicate tally.
    bit       m_ha;
    bit       m_hb;
    bit [1:0] m_a;
    bit [1:0] m_b;
    int       m_dup;

    tdm_demux #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a_data    (a_data),
        .b_data    (b_data),
        .dup_cnt   (dup_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit s, input bit [1:0] d, input bit r, input bit rs);
        if (!rs) begin
            m_ha = 0; m_hb = 0; m_a = 0; m_b = 0; m_dup = 0;
        end else if (m_ha && m_hb) begin
            if (r) begin
                m_ha = 0;
                m_hb = 0;
            end
        end else if (v) begin
            if (s) begin
                if (m_hb && m_dup < 255) m_dup++;
                m_b  = d;
                m_hb = 1;
            end else begin
                if (m_ha && m_dup < 255) m_dup++;
                m_a  = d;
                m_ha = 1;
            end
        end
    endtask

    // One clock: drive inputs, check in_ready before the edge, check registered outputs after.
    task automatic cycle(input logic v, input logic s, input logic [1:0] d, input logic r, input logic rs);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        rst_n     = rs;
        #1;
        chk("in_ready", 32'(in_ready), 32'(rs && !(m_ha && m_hb)));
        @(posedge clk);
        model_edge(v, s, d, r, rs);
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(m_ha && m_hb));
        chk("a_data", 32'(a_data), 32'(m_a));
        chk("b_data", 32'(b_data), 32'(m_b));
        chk("dup_cnt", 32'(dup_cnt), 32'(m_dup));
    endtask

    initial begin
        m_ha = 0; m_hb = 0; m_a = 0; m_b = 0; m_dup = 0;

        // Reset with garbage inputs
        cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_dup", 32'(dup_cnt), 32'd0);

        // Basic pair A then B
        cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        chk("pair_valid", 32'(out_valid), 32'd1);
        chk("pair_a", 32'(a_data), 32'h3);
        chk("pair_b", 32'(b_data), 32'h1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
        chk("pair_done", 32'(out_valid), 32'd0);

        // Reverse order gives the same pair
        cycle(1'b1, 1'b1, 2'b01, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 2'b11, 1'b1, 1'b1);
        chk("rev_a", 32'(a_data), 32'h3);
        chk("rev_b", 32'(b_data), 32'h1);
        chk("rev_dup", 32'(dup_cnt), 32'd0);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

        // Back-pressure: words offered while FULL are ignored
        cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'(i), 2'(i), 1'b0, 1'b1);
        end
        chk("bp_a", 32'(a_data), 32'h2);
        chk("bp_b", 32'(b_data), 32'h0);
        cycle(1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("bp_release", 32'(out_valid), 32'd0);
        chk("bp_dup", 32'(dup_cnt), 32'd0);

        // Duplicates
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        chk("dup_cnt1", 32'(dup_cnt), 32'd1);
        chk("dup_a", 32'(a_data), 32'h2);
        chk("dup_b", 32'(b_data), 32'h1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1'b1);

        // Saturation
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
        end
        chk("sat_255", 32'(dup_cnt), 32'd255);
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        chk("sat_hold", 32'(dup_cnt), 32'd255);

        // Mid-pair reset discards the pending A
        cycle(1'b1, 1'b0, 2'b11, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_dup", 32'(dup_cnt), 32'd0);
        chk("mrst_a", 32'(a_data), 32'h0);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 1'b1);
        chk("mrst_haveb", 32'(dup_cnt), 32'd1);
        cycle(1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        chk("mrst_full", 32'(out_valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 2, the channel word width in bits.
REQ-002 The module SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream word present on in_data/in_sel.
REQ-006 in_data  input  WIDTH  time-multiplexed word.
REQ-007 in_sel  input  1  channel tag for in_data: 0 = channel A, 1 = channel B (same encoding as the mux select S).
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 out_ready  input  1  downstream accepts the current pair.
REQ-010 out_valid  output  1  a complete A/B pair is present.
REQ-011 a_data  output  WIDTH  reconstructed channel-A word.
REQ-012 b_data  output  WIDTH  reconstructed channel-B word.
REQ-013 dup_cnt  output  8  saturating count of duplicate-channel words.

Function
REQ-014 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; no other input edge changes state.
REQ-015 A pair transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-016 The state machine SHALL have four states: EMPTY, HAVE_A, HAVE_B and FULL.
REQ-017 In EMPTY: an accepted word with in_sel=0 SHALL load a_data and go to HAVE_A; with in_sel=1 it SHALL load b_data and go to HAVE_B.
REQ-018 In HAVE_A: in_sel=1 SHALL load b_data and go to FULL; in_sel=0 SHALL overwrite a_data, stay in HAVE_A, and increment dup_cnt.
REQ-019 In HAVE_B: in_sel=0 SHALL load a_data and go to FULL; in_sel=1 SHALL overwrite b_data, stay in HAVE_B, and increment dup_cnt.
REQ-020 In FULL: a pair transfer SHALL move the state to EMPTY; otherwise the state SHALL remain FULL.
REQ-021 out_valid SHALL be 1 exactly when the state is FULL, and SHALL be a registered-state decode with no combinational path from any input.
REQ-022 in_ready SHALL be 1 exactly when the state is not FULL and rst_n=1; no word is accepted in FULL, even on the cycle out_ready=1.
REQ-023 Latency: out_valid SHALL rise on the clock edge that accepts the second, completing word; the pair is visible in the following cycle.
REQ-024 a_data and b_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 a_data and b_data SHALL change only on an accepted word for their own channel.
REQ-026 The values are meaningful only while out_valid=1.
REQ-027 dup_cnt SHALL saturate at 255 and never wrap.
REQ-028 dup_cnt SHALL be cleared only by reset.
REQ-029 Arrival order SHALL be irrelevant: A-then-B and B-then-A SHALL both produce the same pair.
REQ-030 out_ready=1 outside FULL SHALL have no effect.
REQ-031 in_valid=1 in FULL SHALL be back-pressured: no state change and no dup_cnt change.

Reset
REQ-032 While rst_n=0 at a rising edge, the state SHALL become EMPTY, with out_valid=0, a_data=0, b_data=0 and dup_cnt=0.
REQ-033 While rst_n=0, in_ready SHALL be held at 0.
REQ-034 Reset asserted mid-pair (HAVE_A, HAVE_B or FULL) SHALL discard the partial or pending pair; no out_valid pulse SHALL follow reset release.
REQ-035 The first word SHALL be accepted on the first edge with rst_n=1 and in_valid=1.

Verification
REQ-036 Basic pair, WIDTH=2: (in_sel=0, in_data=2'b11), then (in_sel=1, in_data=2'b01), out_ready=1 -> out_valid=1 for one cycle with a_data=2'b11, b_data=2'b01, then EMPTY.
REQ-037 Reverse order: B=2'b01 sent first, then A=2'b11 -> same pair as REQ-036; dup_cnt=0.
REQ-038 Back-pressure: complete a pair with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no words consumed; out_ready=1 -> EMPTY next cycle.
REQ-039 Duplicates: A=2'b00 then A=2'b10 then B=2'b01 -> dup_cnt=1, pair a_data=2'b10, b_data=2'b01.
REQ-040 Saturation: 300 consecutive A words -> dup_cnt=255, stays 255.
REQ-041 Mid-pair reset: send A=2'b11, pulse rst_n=0 for one edge, then send B=2'b01 -> no out_valid; state HAVE_B; dup_cnt=0.
